fp32_adder: RTL and testbench

- Pipelined IEEE-754 binary32 adder: result = a + b, round-to-nearest-even.
- Two register stages:
  - stage 1: unpack, special-case detect, align, add/subtract.
  - stage 2: normalize, round, pack.
- Datapath leaf used by the FP arithmetic units.
- Valid-tagged, no backpressure.

---
 rtl/fp32_pkg.sv | 40 ++++
 rtl/fp32_lzc.sv | 14 +
 rtl/fp32_adder.sv | 130 +++++++++++++
 tb/tb_fp32_adder.sv | 117 +++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared binary32 field definitions, constants and operand decode for the FP adder.
// The FP32_ADDER_DENORM_EN macro selects subnormal decoding; without it, subnormals flush to zero.
package fp32_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 2 * BIAS + 1;

  localparam logic [31:0] POS_INF      = 32'h7F800000;
  localparam logic [31:0] NEG_INF      = 32'hFF800000;
  localparam logic [31:0] QNAN_DEFAULT = 32'h7FC00000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   sig;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } fp_unp_t;

  function automatic fp_unp_t fp_unpack(input logic [31:0] x);
    fp_unp_t u;
    u.sign   = x[31];
    u.is_nan = (&x[30:23]) && (|x[22:0]);
    u.is_inf = (&x[30:23]) && !(|x[22:0]);
`ifdef FP32_ADDER_DENORM_EN
    u.is_zero = (x[30:23] == '0) && (x[22:0] == '0);
    u.exp     = (x[30:23] == '0) ? 8'd1 : x[30:23];
    u.sig     = {(x[30:23] != '0), x[22:0]};
`else
    u.is_zero = (x[30:23] == '0);
    u.exp     = x[30:23];
    u.sig     = {1'b1, x[22:0]};
`endif
    return u;
  endfunction

endpackage

// File: rtl/fp32_lzc.sv
// Combinational leading-zero counter over the 27-bit working significand (27 when all-zero).
module fp32_lzc (
  input  logic [26:0] m,
  output logic [4:0]  cnt
);

  always_comb begin
    cnt = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (m[i]) cnt = 5'(26 - i);
    end
  end

endmodule

// File: rtl/fp32_adder.sv
// Two-stage IEEE-754 binary32 adder, round-to-nearest-even, valid-tagged without backpressure.
// Build option FP32_ADDER_DENORM_EN enables subnormal inputs/results; otherwise flush-to-zero.
module fp32_adder
  import fp32_pkg::*;
#(
  parameter logic [31:0] QNAN = QNAN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [31:0] result
);

  function automatic logic rne(input logic [3:0] lgrs);
    return lgrs[2] & (lgrs[3] | lgrs[1] | lgrs[0]);
  endfunction

  fp_unp_t     ua, ub;
  logic        big_sign, sml_sign;
  logic [7:0]  big_exp, sml_exp;
  logic [23:0] big_sig, sml_sig;
  logic [8:0]  diff;
  logic [26:0] sml_m;
  logic [53:0] sh;
  logic [27:0] sum_c;
  logic        spec_c;
  logic [31:0] spec_res_c;

  logic        vld_p1, spec_p1, sign_p1;
  logic [31:0] spec_res_p1;
  logic [8:0]  exp_p1;
  logic [27:0] sum_p1;

  always_comb begin
    ua = fp_unpack(a);
    ub = fp_unpack(b);
    if ({ua.exp, ua.sig} >= {ub.exp, ub.sig}) begin
      big_sign = ua.sign; big_exp = ua.exp; big_sig = ua.sig;
      sml_sign = ub.sign; sml_exp = ub.exp; sml_sig = ub.sig;
    end else begin
      big_sign = ub.sign; big_exp = ub.exp; big_sig = ub.sig;
      sml_sign = ua.sign; sml_exp = ua.exp; sml_sig = ua.sig;
    end
    diff = {1'b0, big_exp} - {1'b0, sml_exp};
    sh   = {sml_sig, 30'b0} >> diff;
    // Bits shifted past the round position collapse into the sticky LSB.
    if (diff >= 9'd26) sml_m = {26'b0, |sml_sig};
    else               sml_m = {sh[53:28], sh[27] | (|sh[26:0])};
    if (big_sign == sml_sign) sum_c = {1'b0, big_sig, 3'b0} + {1'b0, sml_m};
    else                      sum_c = {1'b0, big_sig, 3'b0} - {1'b0, sml_m};

    spec_c     = 1'b1;
    spec_res_c = QNAN;
    if (ua.is_nan || ub.is_nan)                           spec_res_c = QNAN;
    else if (ua.is_inf && ub.is_inf && ua.sign != ub.sign) spec_res_c = QNAN;
    else if (ua.is_inf)                                   spec_res_c = ua.sign ? NEG_INF : POS_INF;
    else if (ub.is_inf)                                   spec_res_c = ub.sign ? NEG_INF : POS_INF;
    else if (ua.is_zero && ub.is_zero)                    spec_res_c = {ua.sign & ub.sign, 31'b0};
    else if (ua.is_zero)                                  spec_res_c = b;
    else if (ub.is_zero)                                  spec_res_c = a;
    else                                                  spec_c     = 1'b0;
  end

  // Stage 1 boundary: aligned sum and special-case verdict
  always_ff @(posedge clk) begin
    if (in_valid) begin
      spec_p1     <= spec_c;
      spec_res_p1 <= spec_res_c;
      sign_p1     <= big_sign;
      exp_p1      <= {1'b0, big_exp};
      sum_p1      <= sum_c;
    end
  end

  logic [26:0]        m_pre, m_norm;
  logic [4:0]         lz, shamt;
  logic signed [9:0]  e_pre, e_n;
  logic               rnd;
  logic [30:0]        packed_c;
  logic [31:0]        res_c;

  fp32_lzc u_lzc (.m(m_pre), .cnt(lz));

  always_comb begin
    if (sum_p1[27]) begin
      m_pre = {sum_p1[27:2], sum_p1[1] | sum_p1[0]};
      e_pre = signed'({1'b0, exp_p1}) + 10'sd1;
    end else begin
      m_pre = sum_p1[26:0];
      e_pre = signed'({1'b0, exp_p1});
    end
`ifdef FP32_ADDER_DENORM_EN
    // Stop normalizing at exponent 1 so the value lands as a subnormal.
    if (signed'({5'b0, lz}) >= e_pre) shamt = 5'(e_pre - 10'sd1);
    else                              shamt = lz;
`else
    shamt = lz;
`endif
    m_norm   = m_pre << shamt;
    e_n      = e_pre - signed'({5'b0, shamt});
    rnd      = rne(m_norm[3:0]);
    // Rounding carry ripples into the exponent field, covering renormalization and overflow.
    packed_c = {(m_norm[26] ? e_n[7:0] : 8'd0), m_norm[25:3]} + 31'(rnd);

    if (spec_p1)                          res_c = spec_res_p1;
    else if (m_pre == '0)                 res_c = 32'h0;
    else if (e_n >= 10'(EXP_MAX))         res_c = sign_p1 ? NEG_INF : POS_INF;
`ifndef FP32_ADDER_DENORM_EN
    else if (e_n < 10'sd1)                res_c = {sign_p1, 31'b0};
`endif
    else                                  res_c = {sign_p1, packed_c};
  end

  // Stage 2 boundary: packed result and valid pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      result    <= 32'h0;
    end else begin
      vld_p1    <= in_valid;
      out_valid <= vld_p1;
      if (vld_p1) result <= res_c;
    end
  end

endmodule

// File: tb/tb_fp32_adder.sv
// Directed-vector bench for fp32_adder: single-issue latency, streaming, hold and reset.
module tb_fp32_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a, b;
  logic        out_valid;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  localparam int NV = 20;
  logic [31:0] va [NV];
  logic [31:0] vb [NV];
  logic [31:0] ve [NV];

  always #5 clk = ~clk;

  fp32_adder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a), .b(b), .out_valid(out_valid), .result(result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  initial begin
    va[0]  = 32'h3F800000; vb[0]  = 32'h40000000; ve[0]  = 32'h40400000;
    va[1]  = 32'h40400000; vb[1]  = 32'h40400000; ve[1]  = 32'h40C00000;
    va[2]  = 32'h3F000000; vb[2]  = 32'h3F000000; ve[2]  = 32'h3F800000;
    va[3]  = 32'h7FC00000; vb[3]  = 32'h3F800000; ve[3]  = 32'h7FC00000;
    va[4]  = 32'h7F800000; vb[4]  = 32'h3F800000; ve[4]  = 32'h7F800000;
    va[5]  = 32'h7F800000; vb[5]  = 32'hFF800000; ve[5]  = 32'h7FC00000;
    va[6]  = 32'h3F800000; vb[6]  = 32'hBF800000; ve[6]  = 32'h00000000;
    va[7]  = 32'h40000000; vb[7]  = 32'hC0000000; ve[7]  = 32'h00000000;
    va[8]  = 32'h80000000; vb[8]  = 32'h80000000; ve[8]  = 32'h80000000;
    va[9]  = 32'h3F800000; vb[9]  = 32'h3F000000; ve[9]  = 32'h3FC00000;
    va[10] = 32'h3F800000; vb[10] = 32'h3F400000; ve[10] = 32'h3FE00000;
    va[11] = 32'h3F800000; vb[11] = 32'h3EAAAAAB; ve[11] = 32'h3FAAAAAB;
    va[12] = 32'h7F7FFFFF; vb[12] = 32'h7F7FFFFF; ve[12] = 32'h7F800000;
    va[13] = 32'h3F800000; vb[13] = 32'hBF400000; ve[13] = 32'h3E800000;
    va[14] = 32'hFF800000; vb[14] = 32'h3F800000; ve[14] = 32'hFF800000;
    va[15] = 32'h00000001; vb[15] = 32'h3F800000; ve[15] = 32'h3F800000;
    va[16] = 32'hFFC12345; vb[16] = 32'h00000000; ve[16] = 32'h7FC00000;
    va[17] = 32'hC0400000; vb[17] = 32'h3F800000; ve[17] = 32'hC0000000;
    va[18] = 32'h3F800000; vb[18] = 32'h33800000; ve[18] = 32'h3F800000;
    va[19] = 32'h3F800001; vb[19] = 32'h33800000; ve[19] = 32'h3F800002;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    #12;
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_result", result, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Single issue: out_valid must rise exactly two edges after in_valid is sampled.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      a = va[i]; b = vb[i]; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a = $urandom; b = $urandom;
      check($sformatf("lat1_v%0d", i), 32'(out_valid), 32'h0);
      @(posedge clk); #1;
      check($sformatf("lat2_v%0d", i), 32'(out_valid), 32'h1);
      check($sformatf("res_v%0d", i), result, ve[i]);
    end

    @(posedge clk); #1;
    check("hold_out_valid", 32'(out_valid), 32'h0);
    check("hold_result", result, ve[NV-1]);

    // Back-to-back stream of all vectors.
    for (int i = 0; i < NV + 3; i++) begin
      @(posedge clk); #1;
      if (i >= 2 && i - 2 < NV) begin
        check($sformatf("stream_vld_%0d", i), 32'(out_valid), 32'h1);
        check($sformatf("stream_res_%0d", i - 2), result, ve[i-2]);
      end else begin
        check($sformatf("stream_idle_%0d", i), 32'(out_valid), 32'h0);
      end
      if (i < NV) begin
        a = va[i]; b = vb[i]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0; a = $urandom; b = $urandom;
      end
    end

    // Reset with two operations in flight.
    @(posedge clk); #1;
    a = va[0]; b = vb[0]; in_valid = 1'b1;
    @(posedge clk); #1;
    a = va[1]; b = vb[1]; in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_result", result, 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("postrst_vld_%0d", i), 32'(out_valid), 32'h0);
      check($sformatf("postrst_res_%0d", i), result, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
